// File: rtl/galaga_pkg.sv
// ============================================================================
// Module      : galaga_pkg
// Description : Shared state encoding, default timing constants and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package galaga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPLODE = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_DONE    = 2'd3
    } expl_state_t;

    localparam int DEF_EXPLODE_FRAMES  = 4;
    localparam int DEF_FRAMES_PER_STEP = 8;
    localparam int DEF_RESPAWN_FRAMES  = 60;
    localparam int DEF_SCORE_INC       = 10;
    localparam int SCORE_W             = 16;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// Module      : frame_timer
// Description : Loadable down-counter stepped by frame_tick; expire pulses on
//               the tick that finds the count at zero. Load wins over a tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_timer #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;

    assign expire = frame_tick && (r_count == '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (frame_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/explosion_controller.sv
// ============================================================================
// Module      : explosion_controller
// Description : Enemy-hit responder: hide enemy, animate explosion, respawn
//               delay, score update, then pulse done. Optional animation via
//               macro EXPLOSION_ANIM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module explosion_controller #(
    parameter int EXPLODE_FRAMES  = galaga_pkg::DEF_EXPLODE_FRAMES,
    parameter int FRAMES_PER_STEP = galaga_pkg::DEF_FRAMES_PER_STEP,
    parameter int RESPAWN_FRAMES  = galaga_pkg::DEF_RESPAWN_FRAMES,
    parameter int SCORE_W         = galaga_pkg::SCORE_W,
    parameter int SCORE_INC       = galaga_pkg::DEF_SCORE_INC,
    localparam int c_FRAME_W      = galaga_pkg::width_of(EXPLODE_FRAMES)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 enemy_hit,
    output logic                 done,
    output logic                 enemy_visible,
    output logic                 explode_active,
    output logic [c_FRAME_W-1:0] explode_frame,
    output logic                 laser_retract,
    output logic [SCORE_W-1:0]   score
);

    import galaga_pkg::*;

    localparam int c_TMAX    = (FRAMES_PER_STEP > RESPAWN_FRAMES) ? FRAMES_PER_STEP : RESPAWN_FRAMES;
    localparam int c_TIMER_W = width_of(c_TMAX);
    localparam logic [c_TIMER_W-1:0] c_RESP_LOAD = c_TIMER_W'(RESPAWN_FRAMES - 1);
    localparam logic [SCORE_W-1:0]   c_SCORE_INC = SCORE_W'(SCORE_INC);

    expl_state_t            r_state;
    logic                   r_done;
    logic                   r_visible;
    logic                   r_retract;
    logic [SCORE_W-1:0]     r_score;
    logic                   w_expire;
    logic                   w_load;
    logic [c_TIMER_W-1:0]   w_load_value;
    logic [SCORE_W:0]       w_sum;
    logic [SCORE_W-1:0]     w_score_next;

`ifdef EXPLOSION_ANIM_EN
    localparam logic [c_TIMER_W-1:0] c_STEP_LOAD  = c_TIMER_W'(FRAMES_PER_STEP - 1);
    localparam logic [c_FRAME_W-1:0] c_LAST_FRAME = c_FRAME_W'(EXPLODE_FRAMES - 1);

    logic                 r_explode_active;
    logic [c_FRAME_W-1:0] r_frame;

    assign explode_active = r_explode_active;
    assign explode_frame  = r_frame;
`else
    assign explode_active = 1'b0;
    assign explode_frame  = '0;
`endif

    assign done          = r_done;
    assign enemy_visible = r_visible;
    assign laser_retract = r_retract;
    assign score         = r_score;

    assign w_sum        = {1'b0, r_score} + {1'b0, c_SCORE_INC};
    assign w_score_next = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

    // The single timer is reloaded for each explosion step and the respawn wait.
    always_comb begin
        w_load       = 1'b0;
        w_load_value = c_RESP_LOAD;
        case (r_state)
            ST_IDLE: begin
                if (enemy_hit) begin
                    w_load = 1'b1;
`ifdef EXPLOSION_ANIM_EN
                    w_load_value = c_STEP_LOAD;
`endif
                end
            end
`ifdef EXPLOSION_ANIM_EN
            ST_EXPLODE: begin
                if (w_expire) begin
                    w_load       = 1'b1;
                    w_load_value = (r_frame == c_LAST_FRAME) ? c_RESP_LOAD : c_STEP_LOAD;
                end
            end
`endif
            default: ;
        endcase
    end

    frame_timer #(
        .WIDTH      (c_TIMER_W)
    ) u_frame_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .load       (w_load),
        .load_value (w_load_value),
        .expire     (w_expire)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b0;
            r_visible <= 1'b1;
            r_retract <= 1'b0;
            r_score   <= '0;
`ifdef EXPLOSION_ANIM_EN
            r_explode_active <= 1'b0;
            r_frame          <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_retract <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enemy_hit) begin
                        r_retract <= 1'b1;
                        r_score   <= w_score_next;
                        r_visible <= 1'b0;
`ifdef EXPLOSION_ANIM_EN
                        r_state          <= ST_EXPLODE;
                        r_explode_active <= 1'b1;
                        r_frame          <= '0;
`else
                        r_state <= ST_RESPAWN;
`endif
                    end
                end
`ifdef EXPLOSION_ANIM_EN
                ST_EXPLODE: begin
                    if (w_expire) begin
                        if (r_frame == c_LAST_FRAME) begin
                            r_state          <= ST_RESPAWN;
                            r_explode_active <= 1'b0;
                            r_frame          <= '0;
                        end else begin
                            r_frame <= r_frame + 1'b1;
                        end
                    end
                end
`endif
                ST_RESPAWN: begin
                    if (w_expire) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_visible <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_explosion_controller.sv
// ============================================================================
// Module      : tb_explosion_controller
// Description : Directed bench for explosion_controller; two instances share
//               stimulus (16-bit score +10, 8-bit score +100 for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_explosion_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        enemy_hit = 1'b0;

    logic        a_done, a_visible, a_active, a_retract;
    logic [1:0]  a_frame;
    logic [15:0] a_score;
    logic        b_done, b_visible, b_active, b_retract;
    logic [1:0]  b_frame;
    logic [7:0]  b_score;

    int checks = 0;
    int failures = 0;

`ifdef EXPLOSION_ANIM_EN
    localparam int c_TOTAL_TICKS = 11;
    localparam int c_PRE_RESET   = 4;
`else
    localparam int c_TOTAL_TICKS = 3;
    localparam int c_PRE_RESET   = 1;
`endif

    always #5 Clk = ~Clk;

    explosion_controller #(
        .EXPLODE_FRAMES (4), .FRAMES_PER_STEP (2), .RESPAWN_FRAMES (3),
        .SCORE_W (16), .SCORE_INC (10)
    ) dut_a (
        .Clk (Clk), .Reset (Reset), .frame_tick (frame_tick), .enemy_hit (enemy_hit),
        .done (a_done), .enemy_visible (a_visible), .explode_active (a_active),
        .explode_frame (a_frame), .laser_retract (a_retract), .score (a_score)
    );

    explosion_controller #(
        .EXPLODE_FRAMES (4), .FRAMES_PER_STEP (2), .RESPAWN_FRAMES (3),
        .SCORE_W (8), .SCORE_INC (100)
    ) dut_b (
        .Clk (Clk), .Reset (Reset), .frame_tick (frame_tick), .enemy_hit (enemy_hit),
        .done (b_done), .enemy_visible (b_visible), .explode_active (b_active),
        .explode_frame (b_frame), .laser_retract (b_retract), .score (b_score)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_after_gap();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("gap_done", {31'b0, a_done | b_done}, 32'd0);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_visible"}, {31'b0, a_visible & b_visible}, 32'd1);
        chk({tag, "_score_a"}, {16'b0, a_score}, 32'd0);
        chk({tag, "_score_b"}, {24'b0, b_score}, 32'd0);
        chk({tag, "_done"}, {31'b0, a_done | b_done}, 32'd0);
        chk({tag, "_active"}, {31'b0, a_active | b_active}, 32'd0);
        chk({tag, "_frame"}, {30'b0, a_frame}, 32'd0);
        chk({tag, "_retract"}, {31'b0, a_retract}, 32'd0);
    endtask

    task automatic run_seq(input int exp_a, input int exp_b, input logic coincide);
        enemy_hit  = 1'b1;
        frame_tick = coincide;
        step();
        frame_tick = 1'b0;
        chk("hit_score_a", {16'b0, a_score}, exp_a);
        chk("hit_score_b", {24'b0, b_score}, exp_b);
        chk("hit_retract", {31'b0, a_retract & b_retract}, 32'd1);
        chk("hit_visible", {31'b0, a_visible}, 32'd0);
`ifdef EXPLOSION_ANIM_EN
        chk("hit_active", {31'b0, a_active}, 32'd1);
`else
        chk("hit_active", {31'b0, a_active}, 32'd0);
`endif
        chk("hit_frame", {30'b0, a_frame}, 32'd0);
        step();
        chk("retract_one_cycle", {31'b0, a_retract | b_retract}, 32'd0);
        for (int t = 1; t <= c_TOTAL_TICKS; t++) begin
            tick_after_gap();
`ifdef EXPLOSION_ANIM_EN
            if (t < 8) begin
                chk("anim_frame", {30'b0, a_frame}, t / 2);
                chk("anim_active", {31'b0, a_active}, 32'd1);
            end else begin
                chk("resp_frame", {30'b0, a_frame}, 32'd0);
                chk("resp_active", {31'b0, a_active}, 32'd0);
            end
`else
            chk("noanim_active", {31'b0, a_active | b_active}, 32'd0);
            chk("noanim_frame", {30'b0, a_frame}, 32'd0);
`endif
            if (t < c_TOTAL_TICKS) begin
                chk("early_done", {31'b0, a_done | b_done}, 32'd0);
                chk("seq_visible", {31'b0, a_visible}, 32'd0);
            end else begin
                chk("done_pulse", {31'b0, a_done & b_done}, 32'd1);
            end
        end
        // enemy_hit stays high through the DONE edge, as the detector would hold it.
        step();
        chk("done_cleared", {31'b0, a_done | b_done}, 32'd0);
        chk("visible_back", {31'b0, a_visible & b_visible}, 32'd1);
        enemy_hit = 1'b0;
        step();
        chk("idle_stays", {31'b0, a_visible}, 32'd1);
        chk("idle_no_retract", {31'b0, a_retract}, 32'd0);
        chk("score_held_a", {16'b0, a_score}, exp_a);
    endtask

    initial begin
        #2 Reset = 1'b1;
        #1 check_reset_values("rst_async");
        step();
        step();
        Reset = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_reset_values("idle_tick");

        run_seq(10, 100, 1'b1);
        run_seq(20, 200, 1'b0);
        run_seq(30, 255, 1'b0);

        enemy_hit = 1'b1;
        step();
        chk("pre_rst_score_a", {16'b0, a_score}, 32'd40);
        chk("pre_rst_score_b", {24'b0, b_score}, 32'd255);
        for (int t = 1; t <= c_PRE_RESET; t++) begin
            tick_after_gap();
        end
`ifdef EXPLOSION_ANIM_EN
        chk("pre_rst_frame", {30'b0, a_frame}, 32'd2);
`endif
        Reset = 1'b1;
        #1 check_reset_values("rst_mid");
        #2 Reset = 1'b0;
        run_seq(10, 100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
